// File: rtl/nco_hop_sequencer.sv
// nco_hop_sequencer: frequency-hop sequencer driving an NCO's phase_increment/clk_en.
// Holds a programmable table of phase increments. On start it plays hops 0..hop_last,
// each for dwell+1 cycles. It then pulses done, or wraps to hop 0 when loop is set.
// Optional feature macro: NCO_HOP_RAMP_EN adds ramp_mode/ramp_step. With ramp_mode=1,
// each hop after hop 0 uses the previous increment plus ramp_step (mod 256).
// Ports:
//   clock, reset_n         system clock, asynchronous active-low reset
//   cfg_we/addr/data       hop table write port (accepted in any state)
//   hop_last, dwell, loop  sequence parameters, latched at start
//   start, stop            begin / abort a sequence
//   busy, done, hop_strobe status (all registered)
//   hop_index              index of the current hop
//   phase_increment,clk_en NCO control outputs
//   ramp_mode, ramp_step   (NCO_HOP_RAMP_EN only) ramp controls, latched at start
module nco_hop_sequencer #(
  parameter int unsigned TABLE_DEPTH = 8,
  parameter int unsigned DWELL_W     = 16,
  localparam int unsigned AW         = $clog2(TABLE_DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [7:0]         cfg_data,
  input  logic [AW-1:0]      hop_last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic               hop_strobe,
  output logic [AW-1:0]      hop_index,
  output logic [7:0]         phase_increment,
  output logic               clk_en
`ifdef NCO_HOP_RAMP_EN
  ,
  input  logic               ramp_mode,
  input  logic [7:0]         ramp_step
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         hop_table [TABLE_DEPTH];
  logic [AW-1:0]      last_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q;
  logic [DWELL_W-1:0] cnt;

  logic [AW-1:0]      idx_next_c;
  logic [7:0]         next_pi_c;
  logic [7:0]         first_pi_c;

  // Hop table storage; intentionally not reset.
  always_ff @(posedge clock) begin
    if (cfg_we) begin
      hop_table[cfg_addr] <= cfg_data;
    end
  end

  assign idx_next_c = AW'(hop_index + AW'(1));
  assign first_pi_c = hop_table[AW'(0)];

`ifdef NCO_HOP_RAMP_EN
  logic       ramp_q;
  logic [7:0] step_q;

  // Ramp controls are captured together with the other sequence parameters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ramp_q <= 1'b0;
      step_q <= 8'd0;
    end else if (state == ST_IDLE && start && !stop) begin
      ramp_q <= ramp_mode;
      step_q <= ramp_step;
    end
  end

  // Increment for a hop other than hop 0.
  always_comb begin
    next_pi_c = hop_table[idx_next_c];
    if (ramp_q) begin
      next_pi_c = 8'(phase_increment + step_q);
    end
  end
`else
  // Increment for a hop other than hop 0.
  always_comb begin
    next_pi_c = hop_table[idx_next_c];
  end
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      last_q          <= '0;
      dwell_q         <= '0;
      loop_q          <= 1'b0;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      hop_strobe      <= 1'b0;
      hop_index       <= '0;
      phase_increment <= 8'd0;
      clk_en          <= 1'b0;
    end else begin
      hop_strobe <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          busy            <= 1'b0;
          clk_en          <= 1'b0;
          phase_increment <= 8'd0;
          hop_index       <= '0;
          if (start && !stop) begin
            last_q          <= hop_last;
            dwell_q         <= dwell;
            loop_q          <= loop;
            cnt             <= dwell;
            hop_index       <= '0;
            phase_increment <= first_pi_c;
            hop_strobe      <= 1'b1;
            busy            <= 1'b1;
            clk_en          <= 1'b1;
            state           <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Abort: silence the NCO immediately, no done pulse.
            busy            <= 1'b0;
            clk_en          <= 1'b0;
            phase_increment <= 8'd0;
            hop_index       <= '0;
            state           <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (hop_index < last_q) begin
            hop_index       <= idx_next_c;
            phase_increment <= next_pi_c;
            hop_strobe      <= 1'b1;
            cnt             <= dwell_q;
          end else if (loop_q) begin
            // Wrap restarts from table[0], including in ramp mode.
            hop_index       <= '0;
            phase_increment <= first_pi_c;
            hop_strobe      <= 1'b1;
            cnt             <= dwell_q;
          end else begin
            busy            <= 1'b0;
            clk_en          <= 1'b0;
            phase_increment <= 8'd0;
            hop_index       <= '0;
            done            <= 1'b1;
            state           <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_hop_sequencer.sv
// tb_nco_hop_sequencer: self-checking bench for nco_hop_sequencer (default build).
// Expected hop sequences come from a table model held in the bench: hop n of a
// sequence with dwell D occupies cycles n*(D+1) .. n*(D+1)+D after start.
module tb_nco_hop_sequencer;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_data = '0;
  logic [AW-1:0] hop_last = '0;
  logic [DW-1:0] dwell = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy, done, hop_strobe, clk_en;
  logic [AW-1:0] hop_index;
  logic [7:0]    phase_increment;

  int total = 0;
  int bad   = 0;
  int mdl [8];

  nco_hop_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .hop_last(hop_last), .dwell(dwell), .loop(loop),
    .start(start), .stop(stop),
    .busy(busy), .done(done), .hop_strobe(hop_strobe),
    .hop_index(hop_index), .phase_increment(phase_increment), .clk_en(clk_en)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; checks and drives happen 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = 8'(d);
    tick();
    cfg_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_clk_en"}, 32'(clk_en), 0);
    chk({tag, "_pi"}, 32'(phase_increment), 0);
    chk({tag, "_strobe"}, 32'(hop_strobe), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Plays a non-looping sequence and compares every cycle against the table model.
  task automatic run_seq(input string tag, input int l, input int d);
    int n_cyc;
    int strobes;
    int hop;
    n_cyc = (l + 1) * (d + 1);
    strobes = 0;
    hop_last = AW'(l); dwell = DW'(d); loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble live parameter inputs: the running sequence must not see them.
    hop_last = AW'($urandom_range(7, 0));
    dwell = DW'($urandom_range(9, 0));
    loop = 1'b1;
    for (int c = 0; c < n_cyc; c++) begin
      hop = c / (d + 1);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_clk_en"}, 32'(clk_en), 1);
      chk({tag, "_done_low"}, 32'(done), 0);
      chk({tag, "_pi"}, 32'(phase_increment), 32'(mdl[hop]));
      chk({tag, "_index"}, 32'(hop_index), 32'(hop));
      chk({tag, "_strobe"}, 32'(hop_strobe), 32'((c % (d + 1)) == 0));
      if (hop_strobe) strobes++;
      start = (c == 0);   // start during RUN must be ignored
      tick();
    end
    start = 1'b0;
    chk({tag, "_strobe_count"}, 32'(strobes), 32'(l + 1));
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_clk_en"}, 32'(clk_en), 0);
    chk({tag, "_done_pi"}, 32'(phase_increment), 0);
    tick();
    chk_quiet({tag, "_idle"});
    loop = 1'b0;
  endtask

  initial begin
    int exp_pi;
    int hop;
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk_quiet("reset");
    chk("reset_index", 32'(hop_index), 0);
    reset_n = 1'b1;
    tick();
    chk_quiet("post_reset");

    // Fill the whole table, then the directed 10/20/30/40 sequence
    for (int i = 0; i < 8; i++) wr(i, $urandom_range(255, 1));
    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
    run_seq("basic", 3, 2);

    // Looping sequence with a mid-run write to the active entry, then stop
    hop_last = 3'd3; dwell = 16'd2; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    exp_pi = 0;
    for (int c = 0; c < 30; c++) begin
      hop = (c / 3) % 4;
      if (c % 3 == 0) exp_pi = mdl[hop];  // increment snapshot at hop entry
      chk("loop_busy", 32'(busy), 1);
      chk("loop_done_low", 32'(done), 0);
      chk("loop_pi", 32'(phase_increment), 32'(exp_pi));
      chk("loop_strobe", 32'(hop_strobe), 32'(c % 3 == 0));
      chk("loop_index", 32'(hop_index), 32'(hop));
      if (c == 4) begin
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'd99; mdl[1] = 99;
      end else begin
        cfg_we = 1'b0;
      end
      stop = (c == 29);
      tick();
    end
    stop = 1'b0;
    loop = 1'b0;
    chk_quiet("stop");
    tick();
    chk_quiet("stop_after");
    chk("loop_second_pass_99", 32'(mdl[1]), 99);

    // Shortest sequence: one RUN cycle then done
    run_seq("single", 0, 0);

    // start and stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    tick();
    chk_quiet("start_stop");
    start = 1'b0; stop = 1'b0;
    tick();
    chk_quiet("start_stop_after");

    // Randomized sequences against the model
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 3; w++) wr($urandom_range(7, 0), $urandom_range(255, 0));
      run_seq("rand", $urandom_range(7, 0), $urandom_range(4, 0));
    end

    // Asynchronous reset mid-RUN, table preserved afterwards
    hop_last = 3'd7; dwell = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_reset_busy", 32'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    chk("async_reset_index", 32'(hop_index), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_quiet("after_reset");
    run_seq("table_kept", 7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
